// File: rtl/bcd_to_signed_pkg.sv
// Shared constants and types for the decimal-entry converter and display path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_to_signed_pkg;

  // Converter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Largest legal BCD digit code.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Defaults shared with the display path (5 decimal digits, 17-bit signed data).
  localparam int DEF_DIGITS = 5;
  localparam int DEF_WIDTH  = 17;

endpackage

// File: rtl/bcd_to_signed_if.sv
// Start/done handshake bundle between a requester and the BCD-to-signed converter.
// Latency: n/a (wiring only).
// Backpressure: none; start is sampled only when the converter is idle.
//
// Signals: start (request pulse), bcd_in (packed digits, [3:0] = units),
//          sig_in (1 = positive/zero), data_out (signed result), done (1-cycle
//          pulse), busy, err (bad digit seen), ovf (magnitude out of range).
interface bcd_to_signed_if #(
  parameter int DIGITS = 5,
  parameter int WIDTH  = 17
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  sig_in;
  logic [WIDTH-1:0]      data_out;
  logic                  done;
  logic                  busy;
  logic                  err;
  logic                  ovf;

  modport master (
    output start, bcd_in, sig_in,
    input  data_out, done, busy, err, ovf
  );

  modport slave (
    input  start, bcd_in, sig_in,
    output data_out, done, busy, err, ovf
  );

endinterface

// File: rtl/bcd_to_signed_mac.sv
// Single decimal step: acc*10 + digit, with out-of-range digit detect.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: i_acc (running value), i_digit (BCD code), o_acc (acc*10 + digit,
//        digit forced to 0 when invalid), o_bad (digit code above 9).
module bcd_digit_mac
  import bcd_to_signed_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [3:0]       i_digit,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_bad
);

  logic [3:0] w_digit;

  assign o_bad   = (i_digit > BCD_MAX);
  assign w_digit = o_bad ? 4'd0 : i_digit;

  // *10 built from two shifts; the caller sizes ACC_W so this never wraps.
  assign o_acc = (i_acc << 3) + (i_acc << 1) + ACC_W'(w_digit);

endmodule

// File: rtl/bcd_to_signed.sv
// Sign + packed BCD to two's-complement converter, one digit per clock, MSD first.
// Latency: done pulses DIGITS+1 cycles after start is accepted (6 for 5 digits).
// Backpressure: start is ignored while busy; no queueing.
//
// Ports: i_clock, i_reset (synchronous, active high), bus (slave side of
//        bcd_to_signed_if carrying start/bcd_in/sig_in and the results).
// Build option: define BCD_SATURATE_EN to clamp overflowing results to the
//        signed range; otherwise the low WIDTH bits are returned (wrap).
module bcd_to_signed
  import bcd_to_signed_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  bcd_to_signed_if.slave       bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // One bit wider than both the accumulator and the output so the limit
  // compare and the negation cannot overflow.
  localparam int EXT_W = ((ACC_W > WIDTH) ? ACC_W : WIDTH) + 1;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [ACC_W-1:0]     r_bcd;
  logic                 r_sig;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_err_acc;

  logic [WIDTH-1:0]     r_data;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_err;
  logic                 r_ovf;

  logic [3:0]           w_digit;
  logic [ACC_W-1:0]     w_acc_nxt;
  logic                 w_digit_bad;

  logic [EXT_W-1:0]     w_acc_ext;
  logic [EXT_W-1:0]     w_limit;
  logic [EXT_W-1:0]     w_signed;
  logic                 w_ovf;
  logic [WIDTH-1:0]     w_result;

  // Select the captured digit addressed by the down-counter.
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_cnt == CNT_W'(i)) w_digit = r_bcd[4*i +: 4];
    end
  end

  bcd_digit_mac #(.ACC_W(ACC_W)) u_mac (
    .i_acc   (r_acc),
    .i_digit (w_digit),
    .o_acc   (w_acc_nxt),
    .o_bad   (w_digit_bad)
  );

  // Range check and sign application on the finished magnitude.
  always_comb begin
    w_acc_ext = EXT_W'(r_acc);
    w_limit   = r_sig ? ((EXT_W'(1) << (WIDTH-1)) - EXT_W'(1))
                      :  (EXT_W'(1) << (WIDTH-1));
    w_ovf     = (w_acc_ext > w_limit);
    // Negating a zero magnitude yields zero, so "-0" comes out as 0.
    w_signed  = r_sig ? w_acc_ext : (~w_acc_ext + EXT_W'(1));
`ifdef BCD_SATURATE_EN
    if (w_ovf)
      w_result = r_sig ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    else
      w_result = WIDTH'(w_signed);
`else
    w_result = WIDTH'(w_signed);
`endif
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = CONV;
      CONV:    if (r_cnt == '0) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_bcd     <= '0;
      r_sig     <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_err_acc <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (r_state == FINISH);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_bcd     <= bus.bcd_in;
            r_sig     <= bus.sig_in;
            r_acc     <= '0;
            r_cnt     <= CNT_W'(DIGITS-1);
            r_err_acc <= 1'b0;
          end
        end
        CONV: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_digit_bad) r_err_acc <= 1'b1;
        end
        FINISH: begin
          r_data <= w_result;
          r_err  <= r_err_acc;
          r_ovf  <= w_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out = r_data;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_bcd_to_signed.sv
// Directed bench for bcd_to_signed: reset, signs, range limits, bad digits,
// mid-conversion reset and a continuously held start.
// Expected results are hand-computed decimal values.
module tb_bcd_to_signed;

  localparam int DIGITS = 5;
  localparam int WIDTH  = 17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_to_signed_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

  bcd_to_signed #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int hold_val(input int c);
    return (c * 4099 + 123) % 60000;
  endfunction

  // One conversion: accept, then wait (bounded) for done and check everything.
  task automatic run_conv(input string tag, input logic sig, input logic [4*DIGITS-1:0] bcd,
                          input logic [WIDTH-1:0] exp_data, input logic exp_err,
                          input logic exp_ovf);
    int lat;
    int busy_cnt;
    logic got;
    bus.start  = 1'b1;
    bus.sig_in = sig;
    bus.bcd_in = bcd;
    step();
    // Scramble inputs to prove they were captured at acceptance.
    bus.start  = 1'b0;
    bus.bcd_in = 20'h99999;
    bus.sig_in = ~sig;
    lat = 0;
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.done) got = 1'b1;
      else begin
        if (bus.busy) busy_cnt++;
        lat++;
        step();
      end
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd6);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd6);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_data"}, 32'(bus.data_out), 32'(exp_data));
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    step();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_data_held"}, 32'(bus.data_out), 32'(exp_data));
    check({tag, "_err_held"}, 32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    int dn;
    logic [WIDTH-1:0] exp_ovf_data;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    bus.sig_in = 1'b1;
    step();
    step();
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err",  32'(bus.err),  32'd0);
    check("rst_ovf",  32'(bus.ovf),  32'd0);
    rst = 1'b0;
    step();

    run_conv("pos90",    1'b1, 20'h00090, 17'h0005A, 1'b0, 1'b0);
    run_conv("neg45",    1'b0, 20'h00045, 17'h1FFD3, 1'b0, 1'b0);
    run_conv("negzero",  1'b0, 20'h00000, 17'h00000, 1'b0, 1'b0);
    run_conv("pos65535", 1'b1, 20'h65535, 17'h0FFFF, 1'b0, 1'b0);
    run_conv("neg65536", 1'b0, 20'h65536, 17'h10000, 1'b0, 1'b0);
`ifdef BCD_SATURATE_EN
    exp_ovf_data = 17'h0FFFF;
`else
    exp_ovf_data = 17'h10000;
`endif
    run_conv("pos65536", 1'b1, 20'h65536, exp_ovf_data, 1'b0, 1'b1);
    run_conv("baddigit", 1'b1, 20'h11B11, 17'h02B03, 1'b1, 1'b0);

    // Reset during the third CONV cycle abandons the conversion.
    bus.start  = 1'b1;
    bus.sig_in = 1'b1;
    bus.bcd_in = 20'h12345;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_data", 32'(bus.data_out), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_err",  32'(bus.err),  32'd0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done) dn++;
    end
    check("midrst_no_done", 32'(dn), 32'd0);
    run_conv("after_rst7", 1'b1, 20'h00007, 17'h00007, 1'b0, 1'b0);

    // Start held high with new digits every cycle: accepts at edges 0, 7, 14.
    dn = 0;
    for (int c = 0; c <= 20; c++) begin
      bus.start  = 1'b1;
      bus.sig_in = 1'b1;
      bus.bcd_in = to_bcd(hold_val(c));
      step();
      if (bus.done) dn++;
      if (c == 6 || c == 13 || c == 20) begin
        check("hold_done", 32'(bus.done), 32'd1);
        check("hold_data", 32'(bus.data_out), 32'(hold_val(c - 6)));
      end
    end
    bus.start = 1'b0;
    check("hold_done_count", 32'(dn), 32'd3);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
